// File: rtl/uop_dispatch_queue.sv
// -----------------------------------------------------------------------------
// uop_dispatch_queue
//
// Purpose:
//   Circular buffer between the fusion stage and rename. Each cycle it accepts
//   up to NUM_UOPS_IN uops (only lanes with bit 0 set), packs them densely in
//   lane order, and dispatches up to NUM_UOPS_OUT of the oldest entries into a
//   registered output group. OUT_en is the credit handed back to the fusion
//   stage. The queue is flushed by a mispredict and by reset.
//
// Ports:
//   clk           in   clock, every state update on the rising edge
//   rst           in   synchronous active-high reset, wins over mispredict
//   mispredict    in   flush: empties the queue and invalidates the output group
//   IN_uop        in   NUM_UOPS_IN lanes of UOP_W bits, bit 0 = valid
//   OUT_en        out  registered: room for one in-flight group plus one more
//   IN_stall      in   rename cannot take uops: hold OUT_uop, pop nothing
//   OUT_uop       out  NUM_UOPS_OUT lanes of UOP_W bits, lane 0 oldest
//   OUT_overflow  out  sticky: a push found too little room and lost uops
// -----------------------------------------------------------------------------
module uop_dispatch_queue #(
    parameter int NUM_UOPS_IN  = 4,
    parameter int NUM_UOPS_OUT = 4,
    parameter int BUF_SIZE     = 16,
    parameter int UOP_W        = 74
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mispredict,
    input  logic [NUM_UOPS_IN*UOP_W-1:0]  IN_uop,
    output logic                          OUT_en,
    input  logic                          IN_stall,
    output logic [NUM_UOPS_OUT*UOP_W-1:0] OUT_uop,
    output logic                          OUT_overflow
);

    localparam int PTR_W = $clog2(BUF_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [UOP_W-1:0] uop_t;

    localparam cnt_t BUF_SIZE_C = cnt_t'(BUF_SIZE);
    localparam cnt_t OUT_LANES_C = cnt_t'(NUM_UOPS_OUT);
    // One group may already be in flight when OUT_en is seen, so the credit
    // must cover that group plus the next one.
    localparam cnt_t EN_THRESH_C = cnt_t'(2 * NUM_UOPS_IN);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    uop_t r_buf [BUF_SIZE];
    ptr_t r_wr_ptr;
    ptr_t r_rd_ptr;
    cnt_t r_count;
    uop_t r_out_uop [NUM_UOPS_OUT];
    logic r_out_en;
    logic r_overflow;

    // -------------------------------------------------------------------------
    // Lane views
    // -------------------------------------------------------------------------
    uop_t w_in_lane [NUM_UOPS_IN];

    for (genvar g = 0; g < NUM_UOPS_IN; g++) begin : g_in_lane
        assign w_in_lane[g] = IN_uop[g*UOP_W +: UOP_W];
    end

    for (genvar g = 0; g < NUM_UOPS_OUT; g++) begin : g_out_lane
        assign OUT_uop[g*UOP_W +: UOP_W] = r_out_uop[g];
    end

    assign OUT_en       = r_out_en;
    assign OUT_overflow = r_overflow;

    // -------------------------------------------------------------------------
    // Push side: compact valid lanes onto consecutive addresses starting at the
    // write pointer. Room is judged against the count before this cycle's pop,
    // so a lane that does not fit is dropped even if a pop frees space.
    // -------------------------------------------------------------------------
    logic w_lane_wr   [NUM_UOPS_IN];
    ptr_t w_lane_addr [NUM_UOPS_IN];
    cnt_t w_free;
    cnt_t w_push_cnt;
    logic w_drop;

    // NOTE: w_push_cnt is a running tally inside the loop, so it must be a
    // blocking assignment; every output also gets a default before the loop
    // body branches, which keeps this block free of inferred latches.
    always_comb begin
        w_free     = BUF_SIZE_C - r_count;
        w_push_cnt = '0;
        w_drop     = 1'b0;
        for (int i = 0; i < NUM_UOPS_IN; i++) begin
            w_lane_wr[i]   = 1'b0;
            w_lane_addr[i] = r_wr_ptr + w_push_cnt[PTR_W-1:0];
            if (w_in_lane[i][0]) begin
                if (w_push_cnt < w_free) begin
                    w_lane_wr[i] = 1'b1;
                    w_push_cnt   = w_push_cnt + cnt_t'(1);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pop side: the number popped depends only on the count before this
    // cycle's push, so a freshly pushed uop waits at least one edge.
    // -------------------------------------------------------------------------
    cnt_t w_pop_cnt;
    cnt_t w_count_nxt;
    logic w_out_en_nxt;
    uop_t w_out_nxt [NUM_UOPS_OUT];

    always_comb begin
        if (IN_stall) begin
            w_pop_cnt = '0;
        end else if (r_count < OUT_LANES_C) begin
            w_pop_cnt = r_count;
        end else begin
            w_pop_cnt = OUT_LANES_C;
        end

        w_count_nxt  = r_count + w_push_cnt - w_pop_cnt;
        w_out_en_nxt = (BUF_SIZE_C - w_count_nxt) >= EN_THRESH_C;

        // Stored entries always carry bit 0 = 1, so masking it with the lane
        // select yields the output valid directly.
        for (int i = 0; i < NUM_UOPS_OUT; i++) begin
            w_out_nxt[i]    = r_buf[r_rd_ptr + ptr_t'(i)];
            w_out_nxt[i][0] = w_out_nxt[i][0] & (cnt_t'(i) < w_pop_cnt);
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_en   <= 1'b1;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_UOPS_OUT; i++) begin
                r_out_uop[i] <= '0;
            end
        end else if (mispredict) begin
            // Flush: empty queue, invalidate the group, clear the sticky flag.
            // IN_uop and IN_stall are ignored this cycle.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_out_en   <= 1'b1;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_UOPS_OUT; i++) begin
                r_out_uop[i][0] <= 1'b0;
            end
        end else begin
            r_wr_ptr   <= r_wr_ptr + w_push_cnt[PTR_W-1:0];
            r_rd_ptr   <= r_rd_ptr + w_pop_cnt[PTR_W-1:0];
            r_count    <= w_count_nxt;
            r_out_en   <= w_out_en_nxt;
            r_overflow <= r_overflow | w_drop;
            if (!IN_stall) begin
                for (int i = 0; i < NUM_UOPS_OUT; i++) begin
                    r_out_uop[i] <= w_out_nxt[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Buffer storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (!rst && !mispredict) begin
            for (int i = 0; i < NUM_UOPS_IN; i++) begin
                if (w_lane_wr[i]) begin
                    r_buf[w_lane_addr[i]] <= w_in_lane[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_uop_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_uop_dispatch_queue
//
// Purpose:
//   Self-checking bench for uop_dispatch_queue at default parameters. A queue
//   based reference model tracks the expected contents, output group, OUT_en
//   and OUT_overflow. Directed sequences cover the basic scenarios, then a
//   randomized run mixes stalls, gaps, overflow, mispredicts and resets.
// -----------------------------------------------------------------------------
module tb_uop_dispatch_queue;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int BS = 16;
    localparam int W  = 74;

    logic              clk;
    logic              rst;
    logic              mispredict;
    logic [NI*W-1:0]   IN_uop;
    logic              OUT_en;
    logic              IN_stall;
    logic [NO*W-1:0]   OUT_uop;
    logic              OUT_overflow;

    uop_dispatch_queue #(
        .NUM_UOPS_IN  (NI),
        .NUM_UOPS_OUT (NO),
        .BUF_SIZE     (BS),
        .UOP_W        (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mispredict   (mispredict),
        .IN_uop       (IN_uop),
        .OUT_en       (OUT_en),
        .IN_stall     (IN_stall),
        .OUT_uop      (OUT_uop),
        .OUT_overflow (OUT_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Scoreboard counters and checker
    // -------------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: an ordered list of queued uops
    // -------------------------------------------------------------------------
    logic [W-1:0] m_q [$];
    logic [W-1:0] m_out [NO];
    bit           m_en;
    bit           m_ovf;

    task automatic model_edge(input bit s_rst, input bit s_mp, input bit s_stall,
                              input logic [NI*W-1:0] s_in);
        int pre;
        int k;
        int room;
        int stored;
        logic [W-1:0] u;
        if (s_rst || s_mp) begin
            m_q.delete();
            for (int i = 0; i < NO; i++) m_out[i][0] = 1'b0;
            m_en  = 1'b1;
            m_ovf = 1'b0;
            return;
        end
        pre = m_q.size();
        if (!s_stall) begin
            k = (pre < NO) ? pre : NO;
            for (int i = 0; i < NO; i++) begin
                if (i < k) m_out[i] = m_q.pop_front();
                else       m_out[i][0] = 1'b0;
            end
        end
        room   = BS - pre;
        stored = 0;
        for (int i = 0; i < NI; i++) begin
            u = s_in[i*W +: W];
            if (u[0]) begin
                if (stored < room) begin
                    m_q.push_back(u);
                    stored++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_en = (BS - m_q.size()) >= 2 * NI;
    endtask

    task automatic compare_outputs();
        check("out_en", W'(OUT_en), W'(m_en));
        check("overflow", W'(OUT_overflow), W'(m_ovf));
        for (int i = 0; i < NO; i++) begin
            check($sformatf("lane%0d_valid", i), W'(OUT_uop[i*W]), W'(m_out[i][0]));
            if (m_out[i][0]) begin
                check($sformatf("lane%0d_uop", i), OUT_uop[i*W +: W], m_out[i]);
            end
        end
    endtask

    // One clock: drive away from the edge, let the edge happen, update the
    // model with the same inputs, then sample 1 time unit later.
    task automatic step(input bit s_rst, input bit s_mp, input bit s_stall,
                        input logic [NI*W-1:0] s_in);
        rst        = s_rst;
        mispredict = s_mp;
        IN_stall   = s_stall;
        IN_uop     = s_in;
        @(posedge clk);
        model_edge(s_rst, s_mp, s_stall, s_in);
        #1;
        cyc++;
        compare_outputs();
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    function automatic logic [W-1:0] mk_uop(input bit v);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return {r[W-1:1], v};
    endfunction

    function automatic logic [NI*W-1:0] grp(input logic [NI-1:0] vmask);
        logic [NI*W-1:0] g;
        for (int i = 0; i < NI; i++) g[i*W +: W] = mk_uop(vmask[i]);
        return g;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, grp(4'b0000));
    endtask

    task automatic flush();
        step(1'b0, 1'b1, 1'b0, grp(4'b1111));
    endtask

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        logic [NI-1:0] mask;
        bit r_stall;
        bit r_mp;
        bit r_rst;

        for (int i = 0; i < NO; i++) m_out[i] = '0;
        m_en  = 1'b1;
        m_ovf = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, grp(4'b1111));
        step(1'b1, 1'b0, 1'b0, grp(4'b0000));

        // Four valid lanes, dispatched together one edge later
        step(1'b0, 1'b0, 1'b0, grp(4'b1111));
        idle(2);

        // Lane gaps are compacted: lanes 0 and 2 become out lanes 0 and 1
        step(1'b0, 1'b0, 1'b0, grp(4'b0101));
        idle(2);

        // Stall while filling: 4, 8, 12 queued, OUT_en falls past 8, then drain
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b0000));
        idle(4);

        // Overflow: 14 queued under stall, then four more -> two kept, flag set
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b0011));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        idle(5);

        // Mispredict at 10 queued with valid input present and stall raised
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b0011));
        step(1'b0, 1'b1, 1'b1, grp(4'b1111));
        idle(2);

        // Pointer wrap: advance write pointer to 14, then push across the end
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b0011));
        idle(5);
        step(1'b0, 1'b0, 1'b0, grp(4'b1111));
        idle(2);

        // Reset mid-operation discards everything queued
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b0, 1'b0, 1'b1, grp(4'b1111));
        step(1'b1, 1'b1, 1'b0, grp(4'b1111));
        idle(3);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            r_stall = ($urandom_range(0, 9) < 3);
            r_mp    = ($urandom_range(0, 59) == 0);
            r_rst   = ($urandom_range(0, 149) == 0);
            mask    = NI'($urandom_range(0, 15));
            if (!m_en && $urandom_range(0, 3) != 0) mask = '0;
            step(r_rst, r_mp, r_stall, grp(mask));
        end
        flush();
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
